// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a length-prefixed program image over UART 8N1,
// packs big-endian bytes into INSTR_WIDTH-bit words and writes them into
// instruction memory. It then asserts load_done, or asserts load_error on a
// framing error, a length out of range, or an inter-byte timeout.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// after the payload.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned INSTR_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   UART_TXD_IN,
  input  logic                   restart,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   busy,
  output logic [15:0]            words_loaded
);

  localparam int unsigned BYTES  = INSTR_WIDTH / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [32:0] DEPTH  = 33'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERROR} state_t;

  logic             rxd_s1, rxd_s2, rxd_s3;
  logic             rx_fall;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             bit_half, bit_end;
  logic [7:0]       rx_byte;
  logic             byte_valid, frame_err;

  state_t                  state, state_next;
  logic [7:0]              len_hi;
  logic [15:0]             n_words;
  logic [INSTR_WIDTH-1:0]  word, word_shift;
  logic [BCNT_W-1:0]       bcnt;
  logic                    word_complete, last_word, too_big;
  logic [TMO_W-1:0]        tmo;
  logic                    tmo_hit;
  logic                    do_write, done_d, error_d, busy_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= UART_TXD_IN;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  // An edge needs the line high first, so after restart a low line is ignored
  assign rx_fall  = rxd_s3 & ~rxd_s2;
  assign bit_half = (bit_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // RX state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next-state: start re-check at half bit, data and stop at bit centres
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (bit_half) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_end) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
    if (restart) rx_next = RX_IDLE;
  end

  // RX datapath: bit timing, LSB-first shift, byte-valid / framing-error pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (restart) begin
        bit_cnt <= '0;
        bit_idx <= '0;
      end else begin
        case (rx_state)
          RX_START: bit_cnt <= bit_half ? '0 : CNT_W'(bit_cnt + 1'b1);
          RX_DATA: begin
            if (bit_end) begin
              bit_cnt <= '0;
              rx_byte <= {rxd_s2, rx_byte[7:1]};
              bit_idx <= 3'(bit_idx + 1'b1);
            end else begin
              bit_cnt <= CNT_W'(bit_cnt + 1'b1);
            end
          end
          RX_STOP: begin
            if (bit_end) begin
              bit_cnt    <= '0;
              byte_valid <= rxd_s2;
              frame_err  <= ~rxd_s2;
            end else begin
              bit_cnt <= CNT_W'(bit_cnt + 1'b1);
            end
          end
          default: begin
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

  assign word_shift    = INSTR_WIDTH'({word, rx_byte});
  assign word_complete = (bcnt == BCNT_W'(BYTES - 1));
  assign last_word     = ((17'(words_loaded) + 17'd1) == 17'(n_words));
  assign too_big       = (33'({len_hi, rx_byte}) > DEPTH);
  assign tmo_hit       = busy && (rx_state == RX_IDLE) && !byte_valid &&
                         (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Loader state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_LEN_HI;
    else        state <= state_next;
  end

  // Loader next-state; restart overrides everything
  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: begin
        if (frame_err)       state_next = S_ERROR;
        else if (byte_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (frame_err || tmo_hit) state_next = S_ERROR;
        else if (byte_valid) begin
          if ({len_hi, rx_byte} == 16'd0) state_next = S_DONE;
          else if (too_big)               state_next = S_ERROR;
          else                            state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err || tmo_hit) state_next = S_ERROR;
        else if (byte_valid && word_complete && last_word)
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (frame_err || tmo_hit) state_next = S_ERROR;
        else if (byte_valid) state_next = (rx_byte == csum) ? S_DONE : S_ERROR;
      end
`endif
      default: state_next = state;
    endcase
    if (restart) state_next = S_LEN_HI;
  end

  // Loader output decode, registered in the datapath block below
  always_comb begin
    do_write = 1'b0;
    busy_d   = 1'b0;
    do_write = !restart && (state == S_DATA) && byte_valid && word_complete;
    done_d   = (state_next == S_DONE);
    error_d  = (state_next == S_ERROR);
    case (state_next)
      S_LEN_HI:                busy_d = (rx_next != RX_IDLE);
      S_LEN_LO, S_DATA, S_CHK: busy_d = 1'b1;
      default:                 busy_d = 1'b0;
    endcase
  end

  // Loader datapath: length capture, word assembly, write port, timeout
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      busy         <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      n_words      <= '0;
      word         <= '0;
      bcnt         <= '0;
      tmo          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      wr_en      <= do_write;
      load_done  <= done_d;
      load_error <= error_d;
      busy       <= busy_d;
      if (restart) begin
        words_loaded <= '0;
        word         <= '0;
        bcnt         <= '0;
        tmo          <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else begin
        if (do_write) begin
          wr_addr      <= ADDR_WIDTH'(words_loaded);
          wr_data      <= word_shift;
          words_loaded <= 16'(words_loaded + 1'b1);
        end
        if (state == S_LEN_HI && byte_valid) len_hi  <= rx_byte;
        if (state == S_LEN_LO && byte_valid) n_words <= {len_hi, rx_byte};
        if (state == S_DATA && byte_valid) begin
          word <= word_shift;
          bcnt <= word_complete ? '0 : BCNT_W'(bcnt + 1'b1);
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ rx_byte;
`endif
        end
        if (byte_valid)                        tmo <= '0;
        else if (busy && rx_state == RX_IDLE)  tmo <= TMO_W'(tmo + 1'b1);
      end
    end
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Parametrised successor to the fixed 8-bit-PC / 16-bit-instruction UART boot path. Receives a framed program image over UART (8N1) and assembles big-endian bytes into INSTR_WIDTH-bit words. Writes each word into instruction memory through a simple write port, then asserts load_done to release PC control. Adds length header, range checking, inter-byte timeout, error reporting and restart, none of which the current boot path has.

Parameters:
CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); must be >= 4
INSTR_WIDTH, 16, instruction word width in bits; must be a multiple of 8 (8..64)
ADDR_WIDTH, 8, instruction memory address width; capacity 2**ADDR_WIDTH words
TIMEOUT_CYCLES, 1000000, max idle CLK cycles between bytes once a frame has started

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
UART_TXD_IN  input  1  serial data from host, idle high, asynchronous to CLK
restart  input  1  single-cycle pulse; aborts or ends current load and re-arms loader
wr_en  output  1  one-cycle write strobe to instruction memory
wr_addr  output  ADDR_WIDTH  word address for wr_data
wr_data  output  INSTR_WIDTH  assembled instruction word
load_done  output  1  high after a complete, valid image; holds until restart/reset
load_error  output  1  high after framing/range/timeout (or checksum) error; holds until restart/reset
busy  output  1  high from first start bit of a frame until DONE/ERROR
words_loaded  output  16  count of words written in current load

Behaviour:
- Reset (RST_N low, async): all outputs 0, FSM -> LEN_HI, byte/word counters 0, RX engine idle. Reset mid-frame discards partial data; no wr_en pulse emitted.
- RX engine: 2-flop synchroniser on UART_TXD_IN. Start detected on synchronised falling edge; re-checked low at CLKS_PER_BIT/2; 8 data bits LSB-first sampled at bit centres; stop bit sampled at centre. Stop bit 0 = framing error. Byte-valid pulse one cycle after stop-bit sample.
- FSM states: LEN_HI -> LEN_LO -> DATA -> [CHK] -> DONE; any -> ERROR.
  - LEN_HI/LEN_LO: two bytes form 16-bit word count N, big-endian. busy rises on first start bit of LEN_HI.
  - After LEN_LO: N == 0 -> DONE; N > 2**ADDR_WIDTH -> ERROR; else DATA.
  - DATA: bytes shifted into word register MSB-first; after INSTR_WIDTH/8 bytes, wr_en pulses one cycle (cycle after final byte-valid) with wr_addr = words_loaded (truncated to ADDR_WIDTH) and wr_data = word; words_loaded increments in same cycle. After word N -> DONE (or CHK).
  - DONE: load_done = 1, busy = 0. Further UART bytes ignored.
  - ERROR: load_error = 1, busy = 0, load_done = 0. Further bytes ignored.
- Timeout: counter clears on every byte-valid; increments while busy and RX idle; reaching TIMEOUT_CYCLES -> ERROR. Not active in LEN_HI before first start bit.
- Framing error in any busy state -> ERROR.
- restart: in any state, next cycle FSM -> LEN_HI; load_done, load_error, busy, words_loaded cleared; byte in flight discarded (RX returns to idle, waits for line high before next start). restart has priority over a simultaneous byte-valid or write.
- N == 2**ADDR_WIDTH is legal: final wr_addr = all ones, no wrap.
- wr_en never asserted outside DATA; at most one pulse per CLKS_PER_BIT*10 cycles.

Optional Feature:
LOADER_CHECKSUM_EN: when defined, FSM inserts CHK after last data word; one trailing byte must equal XOR of all payload bytes (length bytes excluded). Match -> DONE; mismatch -> ERROR (words already written remain, load_done stays 0). Timeout applies in CHK. When undefined, DATA goes straight to DONE after word N and no trailing byte is expected.

Test Plan:
- CLKS_PER_BIT=16: send 00 03, 12 34, AB CD, 00 FF -> wr_en x3 at addr 0,1,2 with data 0x1234, 0xABCD, 0x00FF; load_done=1, words_loaded=3, load_error=0.
- Send 00 00 -> load_done=1 within 2 cycles of second byte, no wr_en.
- ADDR_WIDTH=8: send 01 01 -> load_error=1, no wr_en; then restart, send 00 01 BE EF -> wr addr 0 = 0xBEEF, load_done=1.
- Send 00 02, 11 22, 33 then idle TIMEOUT_CYCLES=200 -> load_error=1 at cycle 200 after last byte-valid, exactly one wr_en (0x1122).
- Byte with stop bit 0 during DATA -> load_error=1; pulse RST_N low mid-byte -> all outputs 0, next clean frame loads correctly.
- With LOADER_CHECKSUM_EN: 00 01 12 34 26 -> load_done=1; same frame with trailing 27 -> load_error=1.
